// File: rtl/io_fifo_pkg.sv
// Shared sizing helpers for the processor I/O FIFOs (input side now, output side later).
package io_fifo_pkg;

  function automatic int ptrw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cntw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, fill count and empty/full status for a power-of-two FIFO.
module fifo_ptr_ctrl
  import io_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PW = ptrw(DEPTH),
  localparam int CW = cntw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          sel,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  // Status comes from the registered count only; a full FIFO never accepts push-through.
  always_comb begin
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == CW'(DEPTH));
    push_s  = wr_en & ~full_s;
    pop_s   = sel & ~empty_s;
  end

  // Pointer and fill-level state; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign push   = push_s;
  assign pop    = pop_s;
  assign wr_ptr = wr_ptr_r;
  assign rd_ptr = rd_ptr_r;
  assign count  = count_r;
  assign empty  = empty_s;
  assign full   = full_s;

endmodule

// File: rtl/io_in_fifo.sv
// Show-ahead input FIFO feeding the processor io_in port, with sticky ovf/udf flags.
// Optional fill-threshold interrupt enabled by defining IO_IN_FIFO_ITR_EN.
module io_in_fifo
  import io_fifo_pkg::*;
#(
  parameter int NUBITS = 16,
  parameter int FDEPTH = 16,
  parameter int NUIOIN = 2,
  parameter int PADDR  = 0,
  parameter int ITRLVL = 8,
  localparam int PW = ptrw(FDEPTH),
  localparam int CW = cntw(FDEPTH),
  localparam int AW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [NUBITS-1:0] wr_data,
  output logic              wr_ready,
  input  logic              req_in,
  input  logic [AW-1:0]     addr_in,
  output logic [NUBITS-1:0] io_in,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  input  logic              clr_flags,
  output logic              ovf,
  output logic              udf,
  output logic              itr
);

  logic              sel_s;
  logic              push_s;
  logic              pop_s;
  logic [PW-1:0]     wr_ptr_s;
  logic [PW-1:0]     rd_ptr_s;
  logic [CW-1:0]     count_s;
  logic              empty_s;
  logic              full_s;
  logic [NUBITS-1:0] io_in_s;
  logic              ovf_r;
  logic              udf_r;
  logic [NUBITS-1:0] mem_r [FDEPTH];

  assign sel_s = req_in & (addr_in == AW'(PADDR));

  fifo_ptr_ctrl #(
    .DEPTH (FDEPTH)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .sel    (sel_s),
    .push   (push_s),
    .pop    (pop_s),
    .wr_ptr (wr_ptr_s),
    .rd_ptr (rd_ptr_s),
    .count  (count_s),
    .empty  (empty_s),
    .full   (full_s)
  );

  // Storage array; contents are not reset because the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_s] <= wr_data;
    end
  end

  // Head word is shown ahead so the processor reads it with zero latency.
  always_comb begin
    io_in_s = {NUBITS{1'b0}};
    if (!empty_s) begin
      io_in_s = mem_r[rd_ptr_s];
    end else begin
      io_in_s = {NUBITS{1'b0}};
    end
  end

  // Sticky error flags; a set condition beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (wr_en & full_s) begin
        ovf_r <= 1'b1;
      end else if (clr_flags) begin
        ovf_r <= 1'b0;
      end
      if (sel_s & empty_s) begin
        udf_r <= 1'b1;
      end else if (clr_flags) begin
        udf_r <= 1'b0;
      end
    end
  end

`ifdef IO_IN_FIFO_ITR_EN
  logic lvl_prev_r;
  logic itr_r;
  logic lvl_now_s;

  assign lvl_now_s = (count_s >= CW'(ITRLVL));

  // Pulse once on the first cycle the level is seen at/above threshold; re-arms below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_prev_r <= 1'b0;
      itr_r      <= 1'b0;
    end else begin
      lvl_prev_r <= lvl_now_s;
      itr_r      <= lvl_now_s & ~lvl_prev_r;
    end
  end

  assign itr = itr_r;
`else
  assign itr = 1'b0;
`endif

  assign wr_ready = ~full_s;
  assign io_in    = io_in_s;
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_s;
  assign ovf      = ovf_r;
  assign udf      = udf_r;

endmodule
